// File: rtl/fseq_pkg.sv
// Shared types for the fetch sequencer: FSM state encoding and the buffered
// instruction-pair entry.
package fseq_pkg;
    localparam int PC_W = 9;
    localparam int IR_W = 16;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_DISCARD = 2'd2,
        S_FULL    = 2'd3
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            odd;
        logic [IR_W-1:0] ir0;
        logic [IR_W-1:0] ir1;
    } pair_entry_t;
endpackage

// File: rtl/fseq_pair_fifo.sv
// DEPTH-entry FIFO of fetched instruction pairs; head is read combinationally.
// Flush empties the FIFO on the next edge and overrides push/pop.
module fseq_pair_fifo import fseq_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  pair_entry_t              push_entry,
    output pair_entry_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pair_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on their own.
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the even-aligned PC, runs a single-outstanding imem
// handshake, buffers pairs for issue and applies branch redirects.
// Optional stall counter output enabled by defining FSEQ_PERF_EN.
module fetch_sequencer #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 9
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            fetch_next,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [PC_W-1:0] issue_pc,
    output logic [15:0]     p0_ir,
    output logic [15:0]     p1_ir,
    output logic            p0_valid,
    output logic [1:0]      dbg_state
`ifdef FSEQ_PERF_EN
    ,
    output logic [15:0]     perf_stall_cnt
`endif
);
    import fseq_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_q, pend_d;
    logic            odd_q, odd_d;
    logic            push, pop, flush;
    logic [CW-1:0]   count, count_after;
    logic            full, empty;
    pair_entry_t     push_entry, head;
    logic [PC_W-1:0] tgt;

    // imem: imem_req/imem_addr hold until the cycle imem_ack is seen; issue: a pair
    // transfers on any cycle where issue_valid && issue_ready.
    assign pop         = !empty && issue_ready;
    assign count_after = count + CW'(1) - CW'(pop);
    assign tgt         = redirect_valid ? redirect_pc : pend_q;

    always_comb begin
        push_entry.pc  = pc_q;
        push_entry.odd = odd_q;
        push_entry.ir0 = imem_rdata[15:0];
        push_entry.ir1 = imem_rdata[31:16];
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        odd_d    = odd_q;
        pend_d   = pend_q;
        imem_req = 1'b0;
        push     = 1'b0;
        flush    = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = {redirect_pc[PC_W-1:1], 1'b0};
                    odd_d = redirect_pc[0];
                end
            end
            S_REQ: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (imem_ack) begin
                        pc_d  = {redirect_pc[PC_W-1:1], 1'b0};
                        odd_d = redirect_pc[0];
                    end else begin
                        pend_d  = redirect_pc;
                        state_d = S_DISCARD;
                    end
                end else if (imem_ack && !full) begin
                    push  = 1'b1;
                    pc_d  = pc_q + PC_W'(2);
                    odd_d = 1'b0;
                    if (count_after == CW'(DEPTH)) state_d = S_FULL;
                end
            end
            S_DISCARD: begin
                // Old address stays on the bus; its data is dropped when it lands.
                imem_req = 1'b1;
                if (redirect_valid) begin
                    flush  = 1'b1;
                    pend_d = redirect_pc;
                end
                if (imem_ack) begin
                    pc_d    = {tgt[PC_W-1:1], 1'b0};
                    odd_d   = tgt[0];
                    state_d = S_REQ;
                end
            end
            S_FULL: begin
                if (redirect_valid) begin
                    flush   = 1'b1;
                    pc_d    = {redirect_pc[PC_W-1:1], 1'b0};
                    odd_d   = redirect_pc[0];
                    state_d = S_REQ;
                end else if (pop) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            odd_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            odd_q   <= odd_d;
            pend_q  <= pend_d;
        end
    end

    fseq_pair_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .head       (head),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    assign imem_addr   = {pc_q[PC_W-1:1], 1'b0};
    assign fetch_next  = push;
    assign issue_valid = !empty;
    assign issue_pc    = head.pc;
    assign p0_ir       = head.ir0;
    assign p1_ir       = head.ir1;
    assign p0_valid    = empty ? 1'b1 : !head.odd;
    assign dbg_state   = state_q;

`ifdef FSEQ_PERF_EN
    logic [15:0] perf_cnt_q, perf_cnt_d;

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (((state_q == S_FULL) || (empty && state_q != S_IDLE)) && perf_cnt_q != 16'hFFFF)
            perf_cnt_d = perf_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_cnt_q <= '0;
        else     perf_cnt_q <= perf_cnt_d;
    end

    assign perf_stall_cnt = perf_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic checked
// against a program-order model of the fetch and issue streams.
module tb_fetch_sequencer;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [8:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;
    logic        fetch_next;
    logic        issue_valid;
    logic        issue_ready;
    logic [8:0]  issue_pc;
    logic [15:0] p0_ir;
    logic [15:0] p1_ir;
    logic        p0_valid;
    logic [1:0]  dbg_state;
`ifdef FSEQ_PERF_EN
    logic [15:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: expected issue stream as {odd, pc} in program order.
    logic [9:0]  exp_q[$];
    logic [8:0]  exp_fetch_pc;
    logic        fetch_odd;
    logic        stale;
    logic        outstanding;
    logic [8:0]  prev_addr;
    logic [8:0]  slow_addr;
    logic        lat_rand;
    int          wait_cnt;

    always #5 clk = ~clk;

    fetch_sequencer #(.DEPTH(DEPTH), .PC_W(9)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_next     (fetch_next),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_pc       (issue_pc),
        .p0_ir          (p0_ir),
        .p1_ir          (p1_ir),
        .p0_valid       (p0_valid),
        .dbg_state      (dbg_state)
`ifdef FSEQ_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        logic [15:0] w0;
        w0 = 16'h1000 + {7'b0, a} * 16'd7;
        return {w0 ^ 16'hBEEF ^ {a, 7'h0}, w0};
    endfunction

    task automatic do_reset();
        rst            = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        issue_ready    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_addr", imem_addr, 9'h000);
        check_eq("rst_fetch_next", fetch_next, 1'b0);
        check_eq("rst_issue_valid", issue_valid, 1'b0);
        check_eq("rst_p0_valid", p0_valid, 1'b1);
        check_eq("rst_state", dbg_state, 2'd0);
`ifdef FSEQ_PERF_EN
        check_eq("rst_perf", perf_stall_cnt, 16'h0);
`endif
        rst = 1'b0;
        #1;
        check_eq("idle_req", imem_req, 1'b0);
        exp_q.delete();
        exp_fetch_pc = '0;
        fetch_odd    = 1'b0;
        stale        = 1'b0;
        outstanding  = 1'b0;
        prev_addr    = '0;
        wait_cnt     = 0;
    endtask

    // One clock cycle: drive inputs at negedge, answer imem, check, update model.
    task automatic step(input logic rdy, input logic rd, input logic [8:0] rpc);
        logic        fe;
        logic        pop_m;
        logic [9:0]  hd;
        logic [31:0] w;
        @(negedge clk);
        issue_ready    = rdy;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_ack       = 1'b0;
        imem_rdata     = $urandom;
        if (imem_req) begin
            if (!outstanding) begin
                if (imem_addr == slow_addr) wait_cnt = 3;
                else if (lat_rand)          wait_cnt = $urandom_range(0, 3);
                else                        wait_cnt = 0;
            end
            if (wait_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
            end else begin
                wait_cnt--;
            end
        end
        #1;
        check_eq("imem_req", imem_req, exp_q.size() != DEPTH);
        if (outstanding)
            check_eq("addr_hold", imem_addr, prev_addr);
        else if (imem_req && !stale)
            check_eq("imem_addr", imem_addr, exp_fetch_pc);
        fe = imem_req && imem_ack && !rd && !stale;
        check_eq("fetch_next", fetch_next, fe);
        check_eq("issue_valid", issue_valid, exp_q.size() != 0);
        pop_m = rdy && (exp_q.size() != 0);
        if (pop_m) begin
            hd = exp_q.pop_front();
            w  = mem_word(hd[8:0]);
            check_eq("issue_pc", issue_pc, hd[8:0]);
            check_eq("p0_valid", p0_valid, !hd[9]);
            check_eq("p0_ir", p0_ir, w[15:0]);
            check_eq("p1_ir", p1_ir, w[31:16]);
        end
        if (imem_req && imem_ack) stale = 1'b0;
        else if (imem_req && rd)  stale = 1'b1;
        if (rd) begin
            exp_q.delete();
            exp_fetch_pc = {rpc[8:1], 1'b0};
            fetch_odd    = rpc[0];
        end else if (fe) begin
            exp_q.push_back({fetch_odd, exp_fetch_pc});
            exp_fetch_pc = exp_fetch_pc + 9'd2;
            fetch_odd    = 1'b0;
        end
        outstanding = imem_req && !imem_ack;
        prev_addr   = imem_addr;
    endtask

    initial begin
        logic found;
        logic seen_top;
`ifdef FSEQ_PERF_EN
        logic [15:0] perf0;
`endif
        lat_rand  = 1'b0;
        slow_addr = 9'h1FF;

        // Straight-line fetch with single-cycle ack and an always-ready issue stage.
        do_reset();
        repeat (8) step(1'b1, 1'b0, 9'h0);

        // Back-pressure fills the buffer, then one pop restarts fetch at 0x004.
        do_reset();
        repeat (3) step(1'b0, 1'b0, 9'h0);
        check_eq("t2_head_pc", issue_pc, 9'h000);
        check_eq("t2_req_low", imem_req, 1'b0);
        step(1'b1, 1'b0, 9'h0);
        step(1'b0, 1'b0, 9'h0);
        check_eq("t2_refetch_addr", imem_addr, 9'h004);

        // Odd redirect while full.
        step(1'b0, 1'b0, 9'h0);
        step(1'b0, 1'b1, 9'h011);
        step(1'b0, 1'b0, 9'h0);
        check_eq("t3_addr", imem_addr, 9'h010);
        step(1'b0, 1'b0, 9'h0);
        check_eq("t3_head_pc", issue_pc, 9'h010);
        check_eq("t3_p0_valid", p0_valid, 1'b0);
        repeat (4) step(1'b1, 1'b0, 9'h0);

        // Redirect while the request for 0x006 is still in flight.
        do_reset();
        slow_addr = 9'h006;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, 9'h0);
            if (imem_req && imem_addr == 9'h006 && outstanding) found = 1'b1;
        end
        check_eq("t4_slow_req_seen", found, 1'b1);
        step(1'b1, 1'b1, 9'h040);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b1, 1'b0, 9'h0);
            if (imem_req && imem_addr == 9'h040) found = 1'b1;
        end
        check_eq("t4_new_target_req", found, 1'b1);
        slow_addr = 9'h1FF;
        repeat (4) step(1'b1, 1'b0, 9'h0);

        // PC wrap from 0x1FE to 0x000.
        step(1'b1, 1'b1, 9'h1FC);
        seen_top = 1'b0;
        found    = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            step(1'b1, 1'b0, 9'h0);
            if (imem_req && imem_addr == 9'h1FE && fetch_next) seen_top = 1'b1;
            else if (seen_top && imem_req && imem_addr == 9'h000) found = 1'b1;
        end
        check_eq("t5_wrap", found, 1'b1);
        repeat (3) step(1'b1, 1'b0, 9'h0);

`ifdef FSEQ_PERF_EN
        do_reset();
        repeat (3) step(1'b0, 1'b0, 9'h0);
        perf0 = perf_stall_cnt;
        repeat (10) step(1'b0, 1'b0, 9'h0);
        check_eq("perf_full_10", perf_stall_cnt - perf0, 16'd10);
`endif

        // Randomized traffic: variable latency, back-pressure and redirects.
        do_reset();
        lat_rand = 1'b1;
        repeat (3000)
            step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, 9'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end fetch controller for the dual-issue 16-bit core.
- Owns the 9-bit even-aligned PC and runs the single-outstanding instruction-memory handshake.
- Buffers fetched instruction pairs (p0/p1) in a small FIFO and presents them to the issue stage.
- Applies redirects from the branch unit: flushes stale pairs and invalidates p0 when the redirect target is odd.

Parameters:
- DEPTH, 2, number of instruction-pair entries in the pair buffer (power of two, 2..8).
- PC_W, 9, program-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- imem_req  out  1  fetch request; held with stable address until ack
- imem_addr  out  PC_W  fetch address; bit 0 always 0
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  [15:0] = p0 instruction, [31:16] = p1 instruction
- redirect_valid  in  1  branch taken, one-cycle pulse
- redirect_pc  in  PC_W  branch target; may be odd
- fetch_next  out  1  one-cycle pulse when a pair is pushed; drives branch-unit fetch_next_in
- issue_valid  out  1  head pair available
- issue_ready  in  1  issue stage accepts head pair
- issue_pc  out  PC_W  even PC of head pair
- p0_ir  out  16  head p0 instruction
- p1_ir  out  16  head p1 instruction
- p0_valid  out  1  0 when head pair was fetched for an odd redirect target
- perf_stall_cnt  out  16  present only with FSEQ_PERF_EN

Behaviour:
- Reset (async): state=S_IDLE, pc_q=0, odd_q=0, pend_q=0, count=0. Outputs: imem_req=0, fetch_next=0, issue_valid=0, p0_valid=1, perf_stall_cnt=0.
- imem_addr = {pc_q[8:1],1'b0}.
- pc_q advances by +2 per accepted pair, modulo 2^PC_W; 0x1FE wraps to 0x000.
- S_IDLE: imem_req=0. Go to S_REQ the next cycle.
- S_REQ: imem_req=1.
  - ack, no redirect: push {pc_q, odd_q, rdata}, pulse fetch_next, pc_q+=2, odd_q=0. Go to S_FULL if post-update count==DEPTH, else stay in S_REQ.
  - redirect, no ack: flush buffer, pend_q<=redirect_pc, go to S_DISCARD. Address must not change while a request is outstanding.
  - redirect and ack in the same cycle: drop data, flush, pc_q<={redirect_pc[8:1],0}, odd_q<=redirect_pc[0], stay in S_REQ.
- S_DISCARD: imem_req=1 with the old address.
  - ack: drop data, load pc_q/odd_q from pend_q, go to S_REQ.
  - A further redirect overwrites pend_q; if it coincides with ack, the new target wins.
- S_FULL: imem_req=0.
  - Pop: go to S_REQ next cycle.
  - Redirect: flush, load pc_q/odd_q directly from redirect_pc, go to S_REQ.
- Issue side:
  - issue_valid = (count!=0); outputs are driven combinationally from the head entry.
  - p0_valid = ~head.odd.
  - Pop when issue_valid && issue_ready.
- Flush: count becomes 0 on the cycle after the redirect, so issue_valid=0 the next cycle. A pop in the redirect cycle still completes, because that pair carries the branch.
- Push and pop in the same cycle: count is unchanged.
- No push ever occurs when full.
- fetch_next is never asserted for dropped data.

Optional Feature:
- FSEQ_PERF_EN defined:
  - perf_stall_cnt counts cycles where (state==S_FULL) or (issue_valid==0 && state!=S_IDLE).
  - The counter saturates at 0xFFFF and is cleared by rst.
- Undefined: the port and counter logic are absent.

Decomposition:
- fseq_pkg:
  - state enum {S_IDLE, S_REQ, S_DISCARD, S_FULL}
  - pair_entry_t struct {pc[8:0], odd, ir0[15:0], ir1[15:0]}
  - localparams PC_W=9, IR_W=16
- Sub-module fseq_pair_fifo:
  - DEPTH-entry FIFO of pair_entry_t with push/pop/flush.
  - Outputs count, full and empty.
  - Head is read combinationally.

Test Plan:
- Straight-line fetch, 1-cycle ack, issue_ready=1: issue_pc sequence 0x000, 0x002, 0x004, …; a fetch_next pulse per pair; p0_valid=1.
- issue_ready=0, DEPTH=2: two pairs buffered (0x000, 0x002), then imem_req=0 in S_FULL. Raise ready: head 0x000 pops, and a req for 0x004 appears the next cycle.
- redirect_pc=0x011 while in S_FULL: buffer flushed, imem_addr=0x010, first issued pair has issue_pc=0x010 and p0_valid=0, the following pair 0x012 has p0_valid=1.
- Redirect to 0x040 while a request for 0x006 is outstanding (ack delayed 3 cycles): addr stays 0x006 until ack, data dropped with no fetch_next, next req is 0x040.
- pc_q=0x1FE, ack: next imem_addr=0x000.
- With FSEQ_PERF_EN, 10 cycles held in S_FULL: perf_stall_cnt increments by 10.
